// File: rtl/vram_pkg.sv
// Shared definitions for the video DRAM model: cycle-state encoding and
// default array geometry.
package vram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      RD_XFER,
      WR_XFER,
      REFRESH
   } vram_state_e;

   localparam int DEF_DW       = 8;
   localparam int DEF_ROW_BITS = 8;
   localparam int DEF_COL_BITS = 8;

   function automatic int max_bits(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vram_sam_if.sv
// Pin bundle between the VDP (master) and the dual-port VRAM (slave).
interface vram_sam_if
   import vram_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int ROW_BITS = DEF_ROW_BITS,
   parameter int COL_BITS = DEF_COL_BITS,
   parameter int AW       = max_bits(ROW_BITS, COL_BITS)
);

   logic                RAS;
   logic                CAS;
   logic                WE;
   logic                OE;
   logic                SC;
   logic                SE;
   logic [AW-1:0]       AD;
   logic [DW-1:0]       RD_i;
   logic [DW-1:0]       RD_o;
   logic                RD_d;
   logic [DW-1:0]       SD_i;
   logic [DW-1:0]       SD_o;
   logic                SD_d;
   logic [ROW_BITS-1:0] refresh_row;

   modport master (
      output RAS, CAS, WE, OE, SC, SE, AD, RD_i, SD_i,
      input  RD_o, RD_d, SD_o, SD_d, refresh_row
   );

   modport slave (
      input  RAS, CAS, WE, OE, SC, SE, AD, RD_i, SD_i,
      output RD_o, RD_d, SD_o, SD_d, refresh_row
   );

endinterface

// File: rtl/vram_sam_port.sv
// Serial access memory: one row buffer, a wrapping pointer and the SC edge
// logic. Row transfers arrive as load (row -> SAM) and store (SAM -> row).
module vram_sam_port
   import vram_pkg::*;
#(
   parameter  int DW       = DEF_DW,
   parameter  int COL_BITS = DEF_COL_BITS,
   localparam int NCOL     = 1 << COL_BITS
) (
   input  logic                MCLK,
   input  logic                reset,
   input  logic                SC,
   input  logic                SE,
   input  logic [DW-1:0]       SD_i,
   input  logic                load,
   input  logic                store,
   input  logic [COL_BITS-1:0] start_col,
   input  logic [DW-1:0]       row_data [NCOL],
   output logic [DW-1:0]       sam_row  [NCOL],
   output logic [DW-1:0]       SD_o,
   output logic                SD_d
);

   logic [DW-1:0]       sam [NCOL];
   logic [COL_BITS-1:0] ptr;
   logic                mode_in;
   logic                sc_q;
   logic                sc_rise;

   assign sc_rise = SC & ~sc_q;
   assign SD_d    = SE | mode_in;
   assign sam_row = sam;

   always_ff @(posedge MCLK) begin
      sc_q <= SC;
   end

   // A transfer in the same cycle as an SC edge swallows that edge.
   always_ff @(posedge MCLK) begin
      if (reset) begin
         ptr     <= '0;
         mode_in <= 1'b0;
         SD_o    <= '0;
      end else if (load) begin
         ptr     <= start_col;
         mode_in <= 1'b0;
      end else if (store) begin
         ptr     <= start_col;
         mode_in <= 1'b1;
      end else if (sc_rise) begin
         ptr <= ptr + 1'b1;
         if (!mode_in) begin
            SD_o <= sam[ptr];
         end
      end
   end

   always_ff @(posedge MCLK) begin
      if (load) begin
         sam <= row_data;
      end else if (!reset && !store && sc_rise && mode_in && !SE) begin
         sam[ptr] <= SD_i;
      end
   end

endmodule

// File: rtl/vram_sam.sv
// Dual-port video DRAM: RAS/CAS random port with page mode, SAM row
// transfers in both directions and CAS-before-RAS refresh.
module vram_sam
   import vram_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int ROW_BITS = DEF_ROW_BITS,
   parameter int COL_BITS = DEF_COL_BITS,
   parameter int AW       = max_bits(ROW_BITS, COL_BITS)
) (
   input logic       MCLK,
   input logic       reset,
   vram_sam_if.slave bus
);

   localparam int NROW = 1 << ROW_BITS;
   localparam int NCOL = 1 << COL_BITS;

   vram_state_e         state;
   logic                ras_q, cas_q, oe_q;
   logic                ras_fall, ras_rise, cas_fall, oe_rise;
   logic [AW-1:0]       ad;
   logic [ROW_BITS-1:0] row;
   logic [COL_BITS-1:0] col;
   logic [COL_BITS-1:0] col_now;
   logic [DW-1:0]       rd_o;
   logic                rd_d;
   logic [ROW_BITS-1:0] refresh_row;
   logic                wr_word, rd_hit, xfer_load, xfer_store;

   logic [DW-1:0]       mem     [NROW][NCOL];
   logic [DW-1:0]       row_rd  [NCOL];
   logic [DW-1:0]       sam_row [NCOL];

   assign ad       = bus.AD;
   assign ras_fall = ras_q & ~bus.RAS;
   assign ras_rise = ~ras_q & bus.RAS;
   assign cas_fall = cas_q & ~bus.CAS;
   assign oe_rise  = ~oe_q & bus.OE;
   assign row_rd   = mem[row];

   // The column is usable in the same cycle CAS falls, before it is latched.
   always_comb begin
      col_now    = cas_fall ? ad[COL_BITS-1:0] : col;
      wr_word    = 1'b0;
      rd_hit     = 1'b0;
      xfer_load  = 1'b0;
      xfer_store = 1'b0;
      if (!reset) begin
         wr_word    = (state == ACCESS) && !bus.RAS && !bus.CAS && !bus.WE;
         rd_hit     = (state == ACCESS) && !bus.RAS && !bus.CAS && !bus.OE && bus.WE;
         xfer_load  = (state == RD_XFER) && oe_rise;
         xfer_store = (state == WR_XFER) && cas_fall;
      end
   end

   always_ff @(posedge MCLK) begin
      ras_q <= bus.RAS;
      cas_q <= bus.CAS;
      oe_q  <= bus.OE;
   end

   always_ff @(posedge MCLK) begin
      if (xfer_store) begin
         mem[row] <= sam_row;
      end else if (wr_word) begin
         mem[row][col_now] <= bus.RD_i;
      end
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         state       <= IDLE;
         refresh_row <= '0;
         rd_o        <= '0;
         rd_d        <= 1'b1;
      end else begin
         rd_d <= 1'b1;
         if (rd_hit) begin
            rd_o <= mem[row][col_now];
            rd_d <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (ras_fall) begin
                  row <= ad[ROW_BITS-1:0];
                  if (!bus.CAS) begin
                     state       <= REFRESH;
                     refresh_row <= refresh_row + 1'b1;
                  end else if (!bus.OE) begin
                     state <= RD_XFER;
                  end else if (!bus.WE) begin
                     state <= WR_XFER;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS, RD_XFER: begin
               if (cas_fall) begin
                  col <= ad[COL_BITS-1:0];
               end
               if (ras_rise) begin
                  state <= IDLE;
               end
            end
            WR_XFER, REFRESH: begin
               if (ras_rise) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.RD_o        = rd_o;
   assign bus.RD_d        = rd_d;
   assign bus.refresh_row = refresh_row;

   vram_sam_port #(
      .DW       (DW),
      .COL_BITS (COL_BITS)
   ) u_port (
      .MCLK      (MCLK),
      .reset     (reset),
      .SC        (bus.SC),
      .SE        (bus.SE),
      .SD_i      (bus.SD_i),
      .load      (xfer_load),
      .store     (xfer_store),
      .start_col (col_now),
      .row_data  (row_rd),
      .sam_row   (sam_row),
      .SD_o      (bus.SD_o),
      .SD_d      (bus.SD_d)
   );

endmodule
